// File: rtl/decode_stage.sv
// Registered decode stage for the 9-bit core: one instruction per handshake in, one micro-op out.
// SWAP is split into two micro-ops. Define DECODE_ILLEGAL_TRAP_EN to flag op 111/opType 11 as illegal.
module decode_stage #(
  parameter int INSTR_W = 9,
  parameter int PC_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         alu_op,
  output logic [1:0]         op_type,
  output logic [1:0]         rd_addr,
  output logic [1:0]         rs_addr,
  output logic [5:0]         imm,
  output logic               reg_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               branch,
  output logic               jump,
  output logic               swap_second,
  output logic [PC_W-1:0]    pc_out,
  output logic               illegal
);

  localparam logic RUN   = 1'b0;
  localparam logic SWAP2 = 1'b1;

  logic       state_reg;
  logic [2:0] d_op;
  logic [1:0] d_op_type, d_rd, d_rs;
  logic [5:0] d_imm;
  logic       d_rw, d_mr, d_mw, d_br, d_jp, d_swap, d_illegal;
  logic       accept;

  assign in_ready = (state_reg == RUN) && !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign d_op     = in_instr[8:6];

  always_comb begin
    d_op_type = 2'b00;
    d_rd      = 2'b00;
    d_rs      = 2'b00;
    d_imm     = 6'd0;
    d_rw      = 1'b0;
    d_mr      = 1'b0;
    d_mw      = 1'b0;
    d_br      = 1'b0;
    d_jp      = 1'b0;
    d_swap    = 1'b0;
    d_illegal = 1'b0;
    case (d_op)
      3'b000, 3'b111: begin
        d_op_type = in_instr[5:4];
        d_rd      = in_instr[3:2];
        d_rs      = in_instr[1:0];
        d_imm     = {4'b0000, in_instr[1:0]};
      end
      3'b110: d_imm = in_instr[5:0];
      default: begin
        d_rd  = in_instr[5:4];
        d_rs  = in_instr[3:2];
        d_imm = {2'b00, in_instr[3:0]};
      end
    endcase
    case (d_op)
      3'b000, 3'b010, 3'b011: d_rw = 1'b1;
      3'b001: d_br = 1'b1;
      3'b100: begin
        d_mr = 1'b1;
        d_rw = 1'b1;
      end
      3'b101: d_mw = 1'b1;
      3'b110: d_jp = 1'b1;
      default: begin
        // op 111: opType 00/01 are register ops, 10 is SWAP (uop0 writes rd), 11 issues no strobes
        case (in_instr[5:4])
          2'b00, 2'b01: d_rw = 1'b1;
          2'b10: begin
            d_rw   = 1'b1;
            d_swap = 1'b1;
          end
          default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            d_illegal = 1'b1;
`else
            d_illegal = 1'b0;
`endif
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= RUN;
      out_valid   <= 1'b0;
      alu_op      <= 3'b000;
      op_type     <= 2'b00;
      rd_addr     <= 2'b00;
      rs_addr     <= 2'b00;
      imm         <= 6'd0;
      reg_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      branch      <= 1'b0;
      jump        <= 1'b0;
      swap_second <= 1'b0;
      pc_out      <= '0;
    end else if (flush) begin
      state_reg <= RUN;
      out_valid <= 1'b0;
    end else if (state_reg == SWAP2) begin
      // uop1 reuses the held uop0 fields with the register roles exchanged
      if (out_ready) begin
        rd_addr     <= rs_addr;
        rs_addr     <= rd_addr;
        reg_write   <= 1'b1;
        swap_second <= 1'b1;
        out_valid   <= 1'b1;
        state_reg   <= RUN;
      end
    end else if (accept) begin
      out_valid   <= 1'b1;
      alu_op      <= d_op;
      op_type     <= d_op_type;
      rd_addr     <= d_rd;
      rs_addr     <= d_rs;
      imm         <= d_imm;
      reg_write   <= d_rw;
      mem_read    <= d_mr;
      mem_write   <= d_mw;
      branch      <= d_br;
      jump        <= d_jp;
      swap_second <= 1'b0;
      pc_out      <= in_pc;
      state_reg   <= d_swap ? SWAP2 : RUN;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_reg <= 1'b0;
    else if (flush)
      illegal_reg <= 1'b0;
    else if (state_reg == SWAP2) begin
      if (out_ready)
        illegal_reg <= 1'b0;
    end else if (accept)
      illegal_reg <= d_illegal;
  end

  assign illegal = illegal_reg;
`else
  logic unused_illegal;
  assign unused_illegal = d_illegal;
  assign illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected micro-ops are queued when driven, popped when emitted.
module tb_decode_stage;

  typedef struct packed {
    logic [2:0] alu_op;
    logic [1:0] op_type;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [5:0] imm;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       br;
    logic       jp;
    logic       sw2;
    logic [7:0] pc;
    logic       ill;
  } uop_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [8:0] in_instr = '0;
  logic [7:0] in_pc = '0;
  logic       in_ready;
  logic       flush = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] alu_op;
  logic [1:0] op_type, rd_addr, rs_addr;
  logic [5:0] imm;
  logic       reg_write, mem_read, mem_write, branch, jump, swap_second, illegal;
  logic [7:0] pc_out;

  int   checks = 0;
  int   errors = 0;
  uop_t exp_q[$];
  uop_t obs;
  uop_t exp_u;

  localparam logic [8:0] ADD  = 9'b000_00_01_10;
  localparam logic [8:0] LOAD = 9'b100_10_0101;
  localparam logic [8:0] SWAP = 9'b111_10_01_11;
  localparam logic [8:0] ILL  = 9'b111_11_0000;

  always #5 clk = ~clk;

  decode_stage #(.INSTR_W(9), .PC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .op_type(op_type), .rd_addr(rd_addr), .rs_addr(rs_addr), .imm(imm),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .jump(jump), .swap_second(swap_second), .pc_out(pc_out), .illegal(illegal)
  );

  always_comb obs = '{alu_op, op_type, rd_addr, rs_addr, imm, reg_write, mem_read, mem_write,
                      branch, jump, swap_second, pc_out, illegal};

  // Reference decode written straight from the instruction-format table
  function automatic uop_t model(input logic [8:0] i, input logic [7:0] pc, input logic second);
    uop_t u;
    logic [1:0] t;
    u = '0;
    u.alu_op = i[8:6];
    u.pc = pc;
    if (i[8:6] == 3'b000 || i[8:6] == 3'b111) begin
      u.op_type = i[5:4];
      u.rd = i[3:2];
      u.rs = i[1:0];
      u.imm = {4'b0, i[1:0]};
    end else if (i[8:6] == 3'b110) begin
      u.imm = i[5:0];
    end else begin
      u.rd = i[5:4];
      u.rs = i[3:2];
      u.imm = {2'b0, i[3:0]};
    end
    case (i[8:6])
      3'b000, 3'b010, 3'b011: u.rw = 1'b1;
      3'b001: u.br = 1'b1;
      3'b100: begin u.mr = 1'b1; u.rw = 1'b1; end
      3'b101: u.mw = 1'b1;
      3'b110: u.jp = 1'b1;
      default: begin
        if (i[5:4] != 2'b11) u.rw = 1'b1;
`ifdef DECODE_ILLEGAL_TRAP_EN
        else u.ill = 1'b1;
`endif
      end
    endcase
    if (second) begin
      t = u.rd;
      u.rd = u.rs;
      u.rs = t;
      u.sw2 = 1'b1;
    end
    return u;
  endfunction

  task automatic drive(input logic v, input logic [8:0] instr, input logic [7:0] pc,
                       input logic ordy, input logic fl);
    in_valid = v;
    in_instr = instr;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got %h/%b exp 0/0", obs, out_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  task automatic test_add;
    exp_q.push_back(model(ADD, 8'h10, 1'b0));
    drive(1'b1, ADD, 8'h10, 1'b1, 1'b0);
    exp_u = exp_q.pop_front();
    checks++;
    if (obs !== exp_u || out_valid !== 1'b1) begin
      errors++; $display("FAIL add got %h v=%b exp %h", obs, out_valid, exp_u);
    end
    $display("add: uop=%h rd=%0d rs=%0d", obs, rd_addr, rs_addr);
    drive(1'b0, 9'd0, 8'h0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_load_stall;
    uop_t held;
    exp_q.push_back(model(LOAD, 8'h20, 1'b0));
    drive(1'b1, LOAD, 8'h20, 1'b0, 1'b0);
    held = exp_q.pop_front();
    checks++;
    if (obs !== held || out_valid !== 1'b1) begin
      errors++; $display("FAIL load got %h v=%b exp %h", obs, out_valid, held);
    end
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, ADD, 8'h21, 1'b0, 1'b0);
      checks++;
      if (obs !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL load_stall%0d got %h v=%b rdy=%b exp %h 1 0", c, obs, out_valid, in_ready, held);
      end
    end
    $display("load_stall: uop=%h held 3 cycles", obs);
    exp_q.push_back(model(ADD, 8'h21, 1'b0));
    drive(1'b1, ADD, 8'h21, 1'b1, 1'b0);
    exp_u = exp_q.pop_front();
    checks++;
    if (obs !== exp_u || out_valid !== 1'b1) begin
      errors++; $display("FAIL after_stall got %h exp %h", obs, exp_u);
    end
    drive(1'b0, 9'd0, 8'h0, 1'b1, 1'b0);
  endtask

  task automatic test_swap;
    uop_t u0;
    exp_q.push_back(model(SWAP, 8'h30, 1'b0));
    exp_q.push_back(model(SWAP, 8'h30, 1'b1));
    drive(1'b1, SWAP, 8'h30, 1'b1, 1'b0);
    u0 = exp_q.pop_front();
    checks++;
    if (obs !== u0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL swap_uop0 got %h rdy=%b exp %h rdy=0", obs, in_ready, u0);
    end
    drive(1'b1, ADD, 8'h31, 1'b0, 1'b0);
    checks++;
    if (obs !== u0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL swap_hold got %h rdy=%b exp %h rdy=0", obs, in_ready, u0);
    end
    drive(1'b1, ADD, 8'h31, 1'b1, 1'b0);
    exp_u = exp_q.pop_front();
    checks++;
    if (obs !== exp_u || out_valid !== 1'b1) begin
      errors++; $display("FAIL swap_uop1 got %h exp %h", obs, exp_u);
    end
    $display("swap: uop1=%h rd=%0d rs=%0d", obs, rd_addr, rs_addr);
    exp_q.push_back(model(ADD, 8'h31, 1'b0));
    drive(1'b1, ADD, 8'h31, 1'b1, 1'b0);
    exp_u = exp_q.pop_front();
    checks++;
    if (obs !== exp_u) begin
      errors++; $display("FAIL swap_next got %h exp %h", obs, exp_u);
    end
    drive(1'b0, 9'd0, 8'h0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [8:0] prog [8];
    prog = '{9'b001_01_1010, 9'b010_11_0011, 9'b011_00_1111, 9'b101_10_1001,
             9'b110_101101, 9'b111_00_1110, 9'b111_01_0110, 9'b000_11_1001};
    foreach (prog[k]) begin
      exp_q.push_back(model(prog[k], 8'h60 + 8'(k), 1'b0));
      drive(1'b1, prog[k], 8'h60 + 8'(k), 1'b1, 1'b0);
      exp_u = exp_q.pop_front();
      checks++;
      if (obs !== exp_u || out_valid !== 1'b1) begin
        errors++; $display("FAIL b2b%0d got %h v=%b exp %h", k, obs, out_valid, exp_u);
      end
      $display("b2b%0d: instr=%b uop=%h", k, prog[k], obs);
    end
    drive(1'b0, 9'd0, 8'h0, 1'b1, 1'b0);
  endtask

  task automatic test_flush;
    exp_q.push_back(model(SWAP, 8'h40, 1'b0));
    drive(1'b1, SWAP, 8'h40, 1'b1, 1'b0);
    exp_u = exp_q.pop_front();
    checks++;
    if (obs !== exp_u) begin
      errors++; $display("FAIL flush_uop0 got %h exp %h", obs, exp_u);
    end
    drive(1'b1, ADD, 8'h41, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_kill got %b exp 0", out_valid);
    end
    drive(1'b0, 9'd0, 8'h0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_no_uop1 got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    exp_q.push_back(model(ADD, 8'h42, 1'b0));
    drive(1'b1, ADD, 8'h42, 1'b1, 1'b0);
    exp_u = exp_q.pop_front();
    checks++;
    if (obs !== exp_u || out_valid !== 1'b1) begin
      errors++; $display("FAIL flush_after got %h exp %h", obs, exp_u);
    end
    $display("flush: post-flush uop=%h", obs);
    drive(1'b0, 9'd0, 8'h0, 1'b1, 1'b0);
  endtask

  task automatic test_illegal;
    exp_q.push_back(model(ILL, 8'h50, 1'b0));
    drive(1'b1, ILL, 8'h50, 1'b0, 1'b0);
    exp_u = exp_q.pop_front();
    checks++;
    if (obs !== exp_u || out_valid !== 1'b1) begin
      errors++; $display("FAIL illegal got %h v=%b exp %h", obs, out_valid, exp_u);
    end
    drive(1'b0, 9'd0, 8'h0, 1'b0, 1'b0);
    checks++;
    if (obs !== exp_u || out_valid !== 1'b1) begin
      errors++; $display("FAIL illegal_hold got %h exp %h", obs, exp_u);
    end
    $display("illegal: uop=%h illegal=%b", obs, illegal);
    drive(1'b0, 9'd0, 8'h0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_swap;
    exp_q.push_back(model(SWAP, 8'h70, 1'b0));
    exp_q.push_back(model(SWAP, 8'h70, 1'b1));
    drive(1'b1, SWAP, 8'h70, 1'b0, 1'b0);
    exp_u = exp_q.pop_front();
    checks++;
    if (obs !== exp_u) begin
      errors++; $display("FAIL mid_uop0 got %h exp %h", obs, exp_u);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got %h v=%b exp 0 0", obs, out_valid);
    end
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    drive(1'b0, 9'd0, 8'h0, 1'b1, 1'b0);
    drive(1'b0, 9'd0, 8'h0, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_no_uop1 got v=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    $display("reset_mid_swap: out_valid=%b in_ready=%b", out_valid, in_ready);
  endtask

  initial begin
    test_reset;
    test_add;
    test_load_stall;
    test_swap;
    test_back_to_back;
    test_flush;
    test_illegal;
    test_reset_mid_swap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
